// File: rtl/spm_driver_if.sv
// Word-level operand/result handshake bus of the bit-serial multiplier driver.
// The master side supplies operands and consumes products; the driver is the slave.
interface spm_driver_if #(
    parameter int W = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_x;
    logic signed [W-1:0]   in_y;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*W-1:0] out_prod;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/spm_driver.sv
// Parallel front end for the serial-parallel signed multiplier core: streams the
// multiplier LSB-first with sign extension and deserializes the 2W-bit product.
module spm_driver #(
    parameter int W        = 8,
    parameter int CORE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    spm_driver_if.slave         bus,
    output logic signed [W-1:0] core_x,
    output logic                core_y,
    output logic                core_rst,
    input  logic                core_p,
    output logic                busy
);
    localparam int NSH = 2 * W + CORE_LAT;
    localparam int CW  = $clog2(NSH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSH - 1);

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic signed [W-1:0]   x_reg;
    logic signed [W-1:0]   y_sh;
    logic signed [2*W-1:0] prod_sh;

    // Product bits arrive LSB-first, so each new bit enters at the top.
    function automatic logic signed [2*W-1:0] shift_in(input logic signed [2*W-1:0] acc,
                                                       input logic b);
        return {b, acc[2*W-1:1]};
    endfunction

    assign bus.in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_prod  <= '0;
            core_x        <= '0;
            core_y        <= 1'b0;
            core_rst      <= 1'b1;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_rst <= 1'b0;
                    if (bus.in_valid) begin
                        x_reg    <= bus.in_x;
                        y_sh     <= bus.in_y;
                        prod_sh  <= '0;
                        core_x   <= bus.in_x;
                        core_y   <= 1'b0;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CLR;
                    end
                end
                CLR: begin
                    cnt      <= '0;
                    core_rst <= 1'b0;
                    core_x   <= x_reg;
                    core_y   <= y_sh[0];
                    y_sh     <= y_sh >>> 1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    // The first CORE_LAT bits shifted in are flushed out again by
                    // the 2W bits that follow, so no capture gate is needed.
                    prod_sh <= shift_in(prod_sh, core_p);
                    core_y  <= y_sh[0];
                    y_sh    <= y_sh >>> 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bus.out_prod  <= shift_in(prod_sh, core_p);
                        bus.out_valid <= 1'b1;
                        core_y        <= 1'b0;
                        busy          <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
